load_align_unit: RTL and testbench

- Load-side counterpart of the store byte-enable/shift preprocessor: issues word reads to the data memory and returns each loaded value aligned and extended to 32 bits.
- Byte and half-word results are sign- or zero-extended; misaligned accesses follow the same rules as the store side.
- Sits between the load reservation station and the common data bus (CDB). Pipelined: two stages, one accepted request per cycle, valid/ready on both sides, flush support.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/load_align_unit_if.sv | 29 ++
 rtl/load_align_unit_extract.sv | 38 +++
 rtl/load_align_unit.sv | 113 +++++++++++
 tb/tb_load_align_unit.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared load/store memory-access definitions: access-size encodings,
// the funct3 unsigned-bit position and the load stage-1 entry.
package mem_pkg;

    localparam int DATA_W       = 32;
    localparam int LOAD_TAG_W   = 5;
    localparam int UNSIGNED_BIT = 2;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b10;

    typedef struct packed {
        logic [1:0]            offset;
        logic [1:0]            size;
        logic                  is_unsigned;
        logic [LOAD_TAG_W-1:0] tag;
    } ld_entry_t;

    function automatic ld_entry_t make_ld_entry(input logic [1:0]            offset,
                                                input logic [2:0]            funct3,
                                                input logic [LOAD_TAG_W-1:0] tag);
        ld_entry_t e;
        e.offset      = offset;
        e.size        = funct3[1:0];
        e.is_unsigned = funct3[UNSIGNED_BIT];
        e.tag         = tag;
        return e;
    endfunction

endpackage

// File: rtl/load_align_unit_if.sv
// Request, data-memory and CDB-response signals of the load align unit.
interface load_align_unit_if #(
    parameter int WIDTH      = 31,
    parameter int TAG_W      = 5,
    parameter int MEM_ADDR_W = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic [WIDTH:0]        req_addr;
    logic [2:0]            req_funct3;
    logic [TAG_W-1:0]      req_tag;
    logic                  mem_rd_en;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [WIDTH:0]        mem_rdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [WIDTH:0]        resp_data;
    logic [TAG_W-1:0]      resp_tag;

    modport slave (
        input  req_valid, req_addr, req_funct3, req_tag, mem_rdata, resp_ready,
        output req_ready, mem_rd_en, mem_addr, resp_valid, resp_data, resp_tag
    );

    modport master (
        output req_valid, req_addr, req_funct3, req_tag, mem_rdata, resp_ready,
        input  req_ready, mem_rd_en, mem_addr, resp_valid, resp_data, resp_tag
    );
endinterface

// File: rtl/load_align_unit_extract.sv
// Combinational load extraction: selects the addressed byte/half/word of a
// memory word and sign- or zero-extends it to 32 bits.
module load_align_unit_extract
    import mem_pkg::*;
(
    input  logic [DATA_W-1:0] word_i,
    input  logic [1:0]        offset_i,
    input  logic [2:0]        funct3_i,
    output logic [DATA_W-1:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        uns_s;

    // Lane selection and extension; misaligned halves fall back to the low half.
    always_comb begin
        uns_s = funct3_i[UNSIGNED_BIT];
        case (offset_i)
            2'b00:   byte_s = word_i[7:0];
            2'b01:   byte_s = word_i[15:8];
            2'b10:   byte_s = word_i[23:16];
            2'b11:   byte_s = word_i[31:24];
            default: byte_s = word_i[7:0];
        endcase
        if (offset_i == 2'b10) begin
            half_s = word_i[31:16];
        end else begin
            half_s = word_i[15:0];
        end
        case (funct3_i[1:0])
            SIZE_BYTE: data_o = uns_s ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
            SIZE_HALF: data_o = uns_s ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            default:   data_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// Two-stage load unit: issues word reads, parks returned data while the CDB
// stalls, and presents aligned/extended results with their ROB tags.
module load_align_unit
    import mem_pkg::*;
#(
    parameter int WIDTH      = 31,
    parameter int TAG_W      = 5,
    parameter int MEM_ADDR_W = 10
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           flush,
    load_align_unit_if.slave bus
);

    ld_entry_t      s1_q, s1_d;
    logic           s1_valid_q, s1_valid_d;
    logic [WIDTH:0] hold_q, hold_d;
    logic           hold_valid_q, hold_valid_d;
    logic           resp_valid_q, resp_valid_d;
    logic [WIDTH:0] resp_data_q, resp_data_d;
    logic [TAG_W-1:0] resp_tag_q, resp_tag_d;

    logic           adv_s;
    logic           req_ready_s;
    logic           accept_s;
    logic [WIDTH:0] src_word_s;
    logic [WIDTH:0] ext_s;

    assign adv_s       = s1_valid_q && (!resp_valid_q || bus.resp_ready);
    assign req_ready_s = !s1_valid_q || adv_s;
    assign accept_s    = bus.req_valid && req_ready_s && !flush;
    // Memory answers only in the cycle after the read; later cycles use the parked copy.
    assign src_word_s  = hold_valid_q ? hold_q : bus.mem_rdata;

    assign bus.req_ready  = req_ready_s;
    assign bus.mem_rd_en  = accept_s;
    assign bus.mem_addr   = bus.req_addr[MEM_ADDR_W+1:2];
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_tag   = resp_tag_q;

    load_align_unit_extract u_extract (
        .word_i   (src_word_s),
        .offset_i (s1_q.offset),
        .funct3_i ({s1_q.is_unsigned, s1_q.size}),
        .data_o   (ext_s)
    );

    // Next-state logic for stage 1, the hold register and the output register.
    always_comb begin
        s1_d         = s1_q;
        s1_valid_d   = s1_valid_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_tag_d   = resp_tag_q;
        if (flush) begin
            s1_valid_d   = 1'b0;
            hold_valid_d = 1'b0;
            resp_valid_d = 1'b0;
        end else begin
            if (accept_s) begin
                s1_valid_d = 1'b1;
                s1_d       = make_ld_entry(bus.req_addr[1:0], bus.req_funct3, bus.req_tag);
            end else if (adv_s) begin
                s1_valid_d = 1'b0;
            end else begin
                s1_valid_d = s1_valid_q;
            end
            if (adv_s) begin
                hold_valid_d = 1'b0;
            end else if (s1_valid_q && !hold_valid_q) begin
                hold_valid_d = 1'b1;
                hold_d       = bus.mem_rdata;
            end else begin
                hold_valid_d = hold_valid_q;
            end
            if (adv_s) begin
                resp_valid_d = 1'b1;
                resp_data_d  = ext_s;
                resp_tag_d   = s1_q.tag;
            end else if (bus.resp_ready) begin
                resp_valid_d = 1'b0;
            end else begin
                resp_valid_d = resp_valid_q;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_q         <= '0;
            s1_valid_q   <= 1'b0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_tag_q   <= '0;
        end else begin
            s1_q         <= s1_d;
            s1_valid_q   <= s1_valid_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_tag_q   <= resp_tag_d;
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Randomized bench for load_align_unit against an in-order queue model of
// outstanding loads, plus directed vectors with literal expected results.
module tb_load_align_unit;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        int          acc;
        bit          has_lit;
        logic [31:0] lit;
    } ent_t;

    logic clk;
    logic reset_n;
    logic flush;

    load_align_unit_if bus ();

    load_align_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    ent_t        q [$];
    int          cyc;
    int          checks;
    int          errors;
    bit          rd_pend;
    logic [9:0]  rd_idx;
    bit          lit_en;
    logic [31:0] lit_val;
    bit          just_reset;
    bit          exp_valid_g;

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] f3);
        logic [31:0] v;
        int          bits;
        if (f3[1:0] == 2'b00) begin
            bits = 8;
            v    = (w >> (8 * off)) & 32'h0000_00FF;
        end else if (f3[1:0] == 2'b10) begin
            bits = 16;
            v    = ((off == 2'd2) ? (w >> 16) : w) & 32'h0000_FFFF;
        end else begin
            return w;
        end
        if (!f3[2] && v[bits-1]) v = v | (32'hFFFF_FFFF << bits);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_outputs(input logic exp_ready, input logic exp_rd);
        exp_valid_g = (q.size() > 0) && (cyc >= q[0].acc + 2);
        chk("resp_valid", {31'd0, bus.resp_valid}, {31'd0, exp_valid_g});
        if (exp_valid_g) begin
            chk("resp_data", bus.resp_data, q[0].data);
            chk("resp_tag", {27'd0, bus.resp_tag}, {27'd0, q[0].tag});
            if (q[0].has_lit) chk("resp_data_literal", bus.resp_data, q[0].lit);
        end
        if (just_reset) begin
            chk("reset_resp_data", bus.resp_data, 32'h0);
            chk("reset_resp_tag", {27'd0, bus.resp_tag}, 32'h0);
        end
        chk("req_ready", {31'd0, bus.req_ready}, {31'd0, exp_ready});
        chk("mem_rd_en", {31'd0, bus.mem_rd_en}, {31'd0, exp_rd});
        chk("mem_addr", {22'd0, bus.mem_addr}, {22'd0, bus.req_addr[11:2]});
    endtask

    // One clock cycle: present memory data, check outputs, advance the model.
    task automatic step();
        logic exp_ready;
        logic acc;
        logic hs;
        ent_t e;
        bus.mem_rdata = rd_pend ? mem[rd_idx] : $urandom();
        #1;
        exp_ready = (q.size() < 2) || bus.resp_ready;
        acc       = bus.req_valid && exp_ready && !flush;
        check_outputs(exp_ready, acc);
        hs         = exp_valid_g && bus.resp_ready;
        just_reset = !reset_n;
        if (!reset_n || flush) begin
            q.delete();
        end else begin
            if (hs) void'(q.pop_front());
            if (acc) begin
                e.data    = ref_load(mem[bus.req_addr[11:2]], bus.req_addr[1:0], bus.req_funct3);
                e.tag     = bus.req_tag;
                e.acc     = cyc;
                e.has_lit = lit_en;
                e.lit     = lit_val;
                q.push_back(e);
            end
        end
        rd_pend = acc && reset_n;
        rd_idx  = bus.req_addr[11:2];
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive_req(input logic v, input logic [31:0] addr, input logic [2:0] f3,
                             input logic [4:0] tag);
        bus.req_valid  = v;
        bus.req_addr   = addr;
        bus.req_funct3 = f3;
        bus.req_tag    = tag;
    endtask

    task automatic dir_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] tag,
                            input logic [31:0] word, input logic [31:0] lit);
        mem[addr[11:2]] = word;
        bus.resp_ready  = 1'b1;
        drive_req(1'b1, addr, f3, tag);
        lit_en  = 1'b1;
        lit_val = lit;
        step();
        lit_en = 1'b0;
        drive_req(1'b0, 32'h0, 3'b000, 5'd0);
        repeat (3) step();
    endtask

    initial begin
        clk = 1'b0; reset_n = 1'b0; flush = 1'b0;
        checks = 0; errors = 0; cyc = 0; rd_pend = 1'b0; rd_idx = 10'd0;
        lit_en = 1'b0; lit_val = 32'h0; just_reset = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom();
        drive_req(1'b0, 32'h0, 3'b000, 5'd0);
        bus.resp_ready = 1'b0;
        bus.mem_rdata  = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n    = 1'b1;
        just_reset = 1'b1;
        step();

        // Directed vectors with hand-computed results.
        dir_load(32'h0000_0103, 3'b000, 5'd3, 32'h80FF_1234, 32'hFFFF_FF80);
        dir_load(32'h0000_0101, 3'b100, 5'd4, 32'h0000_9A00, 32'h0000_009A);
        dir_load(32'h0000_0102, 3'b110, 5'd5, 32'hBEEF_0000, 32'h0000_BEEF);
        dir_load(32'h0000_0102, 3'b010, 5'd6, 32'hBEEF_0000, 32'hFFFF_BEEF);
        dir_load(32'h0000_0103, 3'b010, 5'd7, 32'h1234_8001, 32'hFFFF_8001);
        dir_load(32'h0000_0102, 3'b101, 5'd8, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // Back-to-back issue with the CDB always ready.
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b1, 32'h200 + 32'(i * 5), 3'(i), 5'(10 + i));
            step();
        end
        drive_req(1'b0, 32'h0, 3'b000, 5'd0);
        repeat (3) step();

        // Backpressure with two loads in flight, then release.
        bus.resp_ready = 1'b0;
        drive_req(1'b1, 32'h0000_0301, 3'b000, 5'd20); step();
        drive_req(1'b1, 32'h0000_0306, 3'b010, 5'd21); step();
        drive_req(1'b1, 32'h0000_0308, 3'b001, 5'd22);
        repeat (3) step();
        drive_req(1'b0, 32'h0, 3'b000, 5'd0);
        bus.resp_ready = 1'b1;
        repeat (4) step();

        // Flush with both stages full while a new request is offered.
        bus.resp_ready = 1'b0;
        drive_req(1'b1, 32'h0000_0400, 3'b101, 5'd1); step();
        drive_req(1'b1, 32'h0000_0404, 3'b101, 5'd2); step();
        step();
        bus.resp_ready = 1'b1;
        flush = 1'b1;
        drive_req(1'b1, 32'h0000_0408, 3'b101, 5'd3); step();
        flush = 1'b0;
        drive_req(1'b0, 32'h0, 3'b000, 5'd0);
        repeat (4) step();

        // Reset in the middle of a stall.
        bus.resp_ready = 1'b0;
        drive_req(1'b1, 32'h0000_0500, 3'b000, 5'd9); step();
        drive_req(1'b1, 32'h0000_0504, 3'b000, 5'd10); step();
        drive_req(1'b0, 32'h0, 3'b000, 5'd0);
        step();
        reset_n = 1'b0; step();
        reset_n = 1'b1; step();
        bus.resp_ready = 1'b1;
        repeat (2) step();

        // Randomized traffic with occasional flushes and resets.
        for (int i = 0; i < 3000; i++) begin
            drive_req($urandom_range(0, 99) < 70, $urandom(), 3'($urandom()), 5'($urandom()));
            bus.resp_ready = $urandom_range(0, 99) < 60;
            flush          = $urandom_range(0, 99) < 3;
            reset_n        = !($urandom_range(0, 999) < 5);
            if (!reset_n) bus.req_valid = 1'b0;
            step();
        end
        reset_n = 1'b1;
        flush   = 1'b0;
        drive_req(1'b0, 32'h0, 3'b000, 5'd0);
        bus.resp_ready = 1'b1;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
